// File: rtl/qpsk_dibit_source_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_pkg
// Description : Shared types and constants for the QPSK dibit source.
// Revision    : 1.0 - initial release
// ============================================================================
package qpsk_pkg;

    typedef logic [1:0] dibit_t;

    localparam dibit_t IDLE_DIBIT  = 2'b00;

    // PN9 x^9 + x^5 + 1: output taken from bit 8, feedback from bits 8 and 4
    localparam int     PN9_LEN     = 9;
    localparam int     PN9_TAP_OUT = 8;
    localparam int     PN9_TAP_FB  = 4;

    localparam int     CARRIER_LEN = 256;

    function automatic dibit_t make_dibit(input logic msb, input logic lsb);
        return {msb, lsb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/qpsk_dibit_source_if.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_dibit_source_if
// Description : Serial bit input handshake and symbol outputs of the source.
// Revision    : 1.0 - initial release
// ============================================================================
interface qpsk_dibit_source_if;

    logic src_sel;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;
    logic dataoutm1;
    logic dataoutm2;
    logic sym_strobe;
    logic underrun;

    modport master (
        output src_sel, bit_in, bit_valid,
        input  bit_ready, dataoutm1, dataoutm2, sym_strobe, underrun
    );

    modport slave (
        input  src_sel, bit_in, bit_valid,
        output bit_ready, dataoutm1, dataoutm2, sym_strobe, underrun
    );

endinterface
`default_nettype wire

// File: rtl/qpsk_dibit_source_pn9_gen.sv
`default_nettype none
// ============================================================================
// Module      : pn9_gen
// Description : Fibonacci PN9 generator that advances only when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module pn9_gen
    import qpsk_pkg::*;
#(
    parameter logic [PN9_LEN-1:0] SEED = 9'h1FF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic bit_o
);

    logic [PN9_LEN-1:0] lfsr_q;
    logic [PN9_LEN-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[PN9_LEN-2:0], lfsr_q[PN9_TAP_OUT] ^ lfsr_q[PN9_TAP_FB]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[PN9_TAP_OUT];

endmodule
`default_nettype wire

// File: rtl/qpsk_dibit_source.sv
`default_nettype none
// ============================================================================
// Module      : qpsk_dibit_source
// Description : Serial/PN9 bits to dibits, 2-deep FIFO, one dibit per symbol.
// Revision    : 1.0 - initial release
// ============================================================================
module qpsk_dibit_source
    import qpsk_pkg::*;
#(
    parameter int           SYM_LEN = CARRIER_LEN,
    parameter logic [8:0]   PN_SEED = 9'h1FF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    qpsk_dibit_source_if.slave   bus
);

    localparam int              CNT_W    = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_LEN - 1);

    logic             src_sel_q,  src_sel_d;
    logic             half_q,     half_d;
    logic             msb_q,      msb_d;
    dibit_t           head_q,     head_d;
    dibit_t           tail_q,     tail_d;
    logic [1:0]       count_q,    count_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    dibit_t           dout_q,     dout_d;
    logic             strobe_q,   strobe_d;
    logic             underrun_q, underrun_d;

    logic   fifo_space;
    logic   ext_ready;
    logic   pn_en;
    logic   pn_bit;
    logic   xfer;
    logic   xbit;
    logic   boundary;
    logic   push;
    logic   pop;
    dibit_t new_dibit;

    pn9_gen #(
        .SEED (PN_SEED)
    ) u_pn9 (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (pn_en),
        .bit_o   (pn_bit)
    );

    assign fifo_space = (count_q != 2'd2);
    assign ext_ready  = fifo_space & ~src_sel_q;
    assign pn_en      = fifo_space & src_sel_q;
    assign xfer       = src_sel_q ? pn_en : (bus.bit_valid & ext_ready);
    assign xbit       = src_sel_q ? pn_bit : bus.bit_in;
    assign boundary   = (cnt_q == CNT_LAST);
    assign push       = xfer & half_q;
    assign pop        = boundary & (count_q != 2'd0);
    assign new_dibit  = make_dibit(msb_q, xbit);

    always_comb begin
        src_sel_d  = bus.src_sel;
        half_d     = half_q;
        msb_d      = msb_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        cnt_d      = boundary ? '0 : cnt_q + CNT_W'(1);
        dout_d     = dout_q;
        strobe_d   = boundary;
        underrun_d = boundary & (count_q == 2'd0);

        if (boundary) begin
            dout_d = (count_q != 2'd0) ? head_q : IDLE_DIBIT;
        end

        // Pop happens ahead of push, so a same-edge push lands behind the popped head
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = new_dibit;
                end else begin
                    tail_d = new_dibit;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    head_d = new_dibit;
                end else begin
                    head_d = tail_q;
                    tail_d = new_dibit;
                end
            end
            default: ;
        endcase

        if (xfer) begin
            if (half_q) begin
                half_d = 1'b0;
            end else begin
                msb_d  = xbit;
                half_d = 1'b1;
            end
        end

        // A source switch drops any half-built dibit; queued dibits survive
        if (bus.src_sel != src_sel_q) begin
            half_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_sel_q  <= 1'b0;
            half_q     <= 1'b0;
            msb_q      <= 1'b0;
            head_q     <= IDLE_DIBIT;
            tail_q     <= IDLE_DIBIT;
            count_q    <= 2'd0;
            cnt_q      <= '0;
            dout_q     <= IDLE_DIBIT;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            src_sel_q  <= src_sel_d;
            half_q     <= half_d;
            msb_q      <= msb_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    assign bus.bit_ready  = ext_ready & reset_n;
    assign bus.dataoutm1  = dout_q[1];
    assign bus.dataoutm2  = dout_q[0];
    assign bus.sym_strobe = strobe_q;
    assign bus.underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_qpsk_dibit_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpsk_dibit_source
// Description : Queue-based reference model feeding a symbol scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpsk_dibit_source;

    localparam int SYM_LEN = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    qpsk_dibit_source_if bus();

    qpsk_dibit_source #(
        .SYM_LEN (SYM_LEN),
        .PN_SEED (9'h1FF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        logic       u;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [1:0] m_fifo[$];
    bit         m_sel, m_half, m_msb;
    int         m_cnt, m_pn_idx;
    bit         pn[511];
    logic [1:0] last_exp = 2'b00;
    bit         acc;
    bit         rsel;

    function automatic void model_reset();
        m_sel    = 1'b0;
        m_half   = 1'b0;
        m_msb    = 1'b0;
        m_cnt    = 0;
        m_pn_idx = 0;
        m_fifo.delete();
        exp_q.delete();
    endfunction

    // One clock of stimulus plus the model's view of the following rising edge
    task automatic cycle(input bit rst, input bit sel, input bit v, input bit b, output bit accepted);
        bit   exp_ready;
        bit   xfer;
        bit   xb;
        exp_t e;
        @(negedge clk);
        reset_n       = rst;
        bus.src_sel   = sel;
        bus.bit_valid = v;
        bus.bit_in    = b;
        #1;
        exp_ready = rst && (m_fifo.size() < 2) && !m_sel;
        checks++;
        if (bus.bit_ready !== exp_ready) begin
            errors++;
            $display("FAIL bit_ready: got %b expected %b at %0t", bus.bit_ready, exp_ready, $time);
        end
        accepted = 1'b0;
        if (!rst) begin
            model_reset();
            checks++;
            if ({bus.dataoutm1, bus.dataoutm2, bus.sym_strobe, bus.underrun} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got m1m2=%b%b strobe=%b underrun=%b expected all 0 at %0t",
                         bus.dataoutm1, bus.dataoutm2, bus.sym_strobe, bus.underrun, $time);
            end
        end else begin
            if (m_sel) begin
                xfer = (m_fifo.size() < 2);
                xb   = pn[m_pn_idx];
                if (xfer) m_pn_idx = (m_pn_idx + 1) % 511;
            end else begin
                xfer = v && exp_ready;
                xb   = b;
            end
            accepted = xfer && !m_sel;
            if (m_cnt == SYM_LEN - 1) begin
                if (m_fifo.size() > 0) begin
                    e.d = m_fifo.pop_front();
                    e.u = 1'b0;
                end else begin
                    e.d = 2'b00;
                    e.u = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (xfer) begin
                if (m_half) begin
                    m_fifo.push_back({m_msb, xb});
                    m_half = 1'b0;
                end else begin
                    m_msb  = xb;
                    m_half = 1'b1;
                end
            end
            if (sel != m_sel) begin
                m_half = 1'b0;
                m_sel  = sel;
            end
            m_cnt = (m_cnt + 1) % SYM_LEN;
        end
    endtask

    task automatic do_reset(input int n);
        bit a;
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic idle(input bit sel, input int n);
        bit a;
        repeat (n) cycle(1'b1, sel, 1'b0, 1'b0, a);
    endtask

    // Bits go out MSB-first and are held until the handshake accepts them
    task automatic send(input logic [31:0] bits, input int n);
        int i;
        int guard;
        bit a;
        i     = 0;
        guard = 0;
        while (i < n && guard < 200) begin
            cycle(1'b1, 1'b0, 1'b1, bits[n-1-i], a);
            if (a) i++;
            guard++;
        end
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sent %0d of %0d bits", i, n);
        end
    endtask

    // Scoreboard monitor: every cycle either a predicted symbol or a held output
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                last_exp = 2'b00;
            end else if (bus.sym_strobe) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: got m1m2=%b%b underrun=%b, no symbol due at %0t",
                             bus.dataoutm1, bus.dataoutm2, bus.underrun, $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.dataoutm1, bus.dataoutm2} !== e.d || bus.underrun !== e.u) begin
                        errors++;
                        $display("FAIL symbol: got m1m2=%b%b underrun=%b expected %b underrun=%b at %0t",
                                 bus.dataoutm1, bus.dataoutm2, bus.underrun, e.d, e.u, $time);
                    end
                    last_exp = e.d;
                end
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_strobe: got strobe=0 expected symbol %b underrun=%b at %0t",
                             e.d, e.u, $time);
                    last_exp = e.d;
                end
                checks++;
                if ({bus.dataoutm1, bus.dataoutm2} !== last_exp || bus.underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL hold: got m1m2=%b%b underrun=%b expected %b underrun=0 at %0t",
                             bus.dataoutm1, bus.dataoutm2, bus.underrun, last_exp, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] seed;
        seed          = 9'h1FF;
        bus.src_sel   = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        reset_n       = 1'b0;
        model_reset();
        // Reference PN9 sequence: o[n+9] = o[n] ^ o[n+4], first nine bits are the seed
        for (int k = 0; k < 9; k++) pn[k] = seed[8-k];
        for (int k = 9; k < 511; k++) pn[k] = pn[k-9] ^ pn[k-5];

        do_reset(3);
        send(32'b1101_0010, 8);
        idle(1'b0, 20);

        do_reset(2);
        send(32'b10, 2);
        idle(1'b0, 12);

        do_reset(2);
        send(32'b1001, 4);
        idle(1'b0, 12);

        do_reset(2);
        send(32'h0000_B5C3, 16);
        idle(1'b0, 24);

        do_reset(2);
        idle(1'b1, 40);
        idle(1'b0, 4);
        idle(1'b1, 1);
        idle(1'b0, 1);
        send(32'b0110, 4);
        idle(1'b0, 12);

        do_reset(2);
        send(32'b1101_10, 6);
        do_reset(1);
        idle(1'b0, 12);

        rsel = 1'b0;
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0, acc);
            end else begin
                if ($urandom_range(0, 39) == 0) rsel = ~rsel;
                cycle(1'b1, rsel, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), acc);
            end
        end
        idle(1'b0, 12);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d symbols still pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
